// File: rtl/rr_arb_mux.sv
// N-input registered mux with a round-robin or fixed-priority arbiter and a
// one-entry valid/ready output stage.

module rr_arb_mux_lane #(
  parameter int DATA_W = 8
) (
  input  logic              sel,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] masked
);
  assign masked = data & {DATA_W{sel}};
endmodule

module rr_arb_mux #(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 8,
  parameter  bit RR_EN  = 1'b1,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req_i,
  input  logic [NUM_CH*DATA_W-1:0] data_i,
  output logic [NUM_CH-1:0]        gnt_o,
  output logic                     valid_o,
  output logic [DATA_W-1:0]        data_o,
  output logic [SEL_W-1:0]         sel_o,
  input  logic                     ready_i
);

  logic [SEL_W-1:0]               ptr_q;
  logic [SEL_W-1:0]               win_idx;
  logic                           found;
  logic [NUM_CH-1:0]              win_onehot;
  logic [NUM_CH-1:0][DATA_W-1:0]  masked;
  logic [DATA_W-1:0]              win_data;
  logic                           can_load;
  logic                           grant_en;

  // Cyclic scan starting at the pointer; first requester wins.
  always_comb begin
    int k;
    found   = 1'b0;
    win_idx = '0;
    k       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      k = int'(ptr_q) + i;
      if (k >= NUM_CH) k = k - NUM_CH;
      if (!found && req_i[k]) begin
        found   = 1'b1;
        win_idx = SEL_W'(k);
      end
    end
  end

  assign win_onehot = found ? (NUM_CH'(1) << win_idx) : '0;
  assign can_load   = ~valid_o | ready_i;
  assign grant_en   = can_load & found & ~reset;
  assign gnt_o      = grant_en ? win_onehot : '0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    rr_arb_mux_lane #(.DATA_W(DATA_W)) u_lane (
      .sel    (win_onehot[g]),
      .data   (data_i[g*DATA_W +: DATA_W]),
      .masked (masked[g])
    );
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_CH; i++) win_data = win_data | masked[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      sel_o   <= '0;
      ptr_q   <= '0;
    end else if (grant_en) begin
      valid_o <= 1'b1;
      data_o  <= win_data;
      sel_o   <= win_idx;
      if (RR_EN)
        ptr_q <= (win_idx == SEL_W'(NUM_CH-1)) ? '0 : win_idx + SEL_W'(1);
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

  a_gnt_onehot0: assert property (@(posedge clk) $onehot0(gnt_o));
  a_gnt_req:     assert property (@(posedge clk) (gnt_o & ~req_i) == '0);
  a_stall_hold:  assert property (@(posedge clk) disable iff (reset)
                   (valid_o && !ready_i) |=> ($stable(data_o) && $stable(sel_o)));
  a_sel_range:   assert property (@(posedge clk) int'(sel_o) < NUM_CH);

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench: one round-robin and one fixed-priority instance share stimulus.

module tb_rr_arb_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] data;
  logic        ready;

  logic [3:0] gnt_r, gnt_f;
  logic       valid_r, valid_f;
  logic [7:0] data_r, data_f;
  logic [1:0] sel_r, sel_f;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_arb_mux #(.NUM_CH(4), .DATA_W(8), .RR_EN(1'b1)) dut_rr (
    .clk(clk), .reset(reset), .req_i(req), .data_i(data), .gnt_o(gnt_r),
    .valid_o(valid_r), .data_o(data_r), .sel_o(sel_r), .ready_i(ready)
  );

  rr_arb_mux #(.NUM_CH(4), .DATA_W(8), .RR_EN(1'b0)) dut_fx (
    .clk(clk), .reset(reset), .req_i(req), .data_i(data), .gnt_o(gnt_f),
    .valid_o(valid_f), .data_o(data_f), .sel_o(sel_f), .ready_i(ready)
  );

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 4'b1111; ready = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_r !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt_r); end
    @(posedge clk); #1;
    checks++;
    if (valid_r !== 1'b0 || data_r !== 8'h00 || sel_r !== 2'd0) begin
      failures++; $display("FAIL reset_regs got v=%b d=%h s=%0d exp v=0 d=00 s=0", valid_r, data_r, sel_r);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt_r !== 4'b0001) begin failures++; $display("FAIL reset_release_gnt got=%b exp=0001", gnt_r); end
    @(posedge clk); #1;
  endtask

  task automatic test_rr_rotate();
    logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_reset();
    req = 4'b1111; ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (gnt_r !== (4'b0001 << (i % 4))) begin
        failures++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", i, gnt_r, 4'b0001 << (i % 4));
      end
      @(posedge clk); #1;
      checks++;
      if (valid_r !== 1'b1 || data_r !== exp_d[i % 4] || sel_r !== 2'(i % 4)) begin
        failures++; $display("FAIL rr_data[%0d] got v=%b d=%h s=%0d exp v=1 d=%h s=%0d",
                             i, valid_r, data_r, sel_r, exp_d[i % 4], i % 4);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    req = 4'b0010;
    @(negedge clk);
    checks++;
    if (gnt_r !== 4'b0010) begin failures++; $display("FAIL wrap_setup got=%b exp=0010", gnt_r); end
    @(posedge clk); #1;
    req = 4'b0011;
    @(negedge clk);
    checks++;
    if (gnt_r !== 4'b0001) begin failures++; $display("FAIL wrap_gnt got=%b exp=0001", gnt_r); end
    @(posedge clk); #1;
    checks++;
    if (sel_r !== 2'd0 || data_r !== 8'h11) begin
      failures++; $display("FAIL wrap_sel got s=%0d d=%h exp s=0 d=11", sel_r, data_r);
    end
    @(negedge clk);
    checks++;
    if (gnt_r !== 4'b0010) begin failures++; $display("FAIL wrap_ptr1 got=%b exp=0010", gnt_r); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 4'b0010;
    @(posedge clk); #1;
    ready = 1'b0; req = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (gnt_r !== 4'b0000) begin failures++; $display("FAIL stall_gnt[%0d] got=%b exp=0000", i, gnt_r); end
      @(posedge clk); #1;
      checks++;
      if (valid_r !== 1'b1 || data_r !== 8'h22 || sel_r !== 2'd1) begin
        failures++; $display("FAIL stall_hold[%0d] got v=%b d=%h s=%0d exp v=1 d=22 s=1", i, valid_r, data_r, sel_r);
      end
    end
    ready = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_r !== 4'b0100) begin failures++; $display("FAIL unstall_gnt got=%b exp=0100", gnt_r); end
    @(posedge clk); #1;
    checks++;
    if (valid_r !== 1'b1 || data_r !== 8'h33 || sel_r !== 2'd2) begin
      failures++; $display("FAIL unstall_load got v=%b d=%h s=%0d exp v=1 d=33 s=2", valid_r, data_r, sel_r);
    end
    req = 4'b0000;
    @(posedge clk); #1;
    checks++;
    if (valid_r !== 1'b0 || data_r !== 8'h33) begin
      failures++; $display("FAIL pop_drain got v=%b d=%h exp v=0 d=33", valid_r, data_r);
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    req = 4'b1010; ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (gnt_f !== 4'b0010) begin failures++; $display("FAIL fixed_gnt[%0d] got=%b exp=0010", i, gnt_f); end
      @(posedge clk); #1;
      checks++;
      if (valid_f !== 1'b1 || data_f !== 8'h22 || sel_f !== 2'd1) begin
        failures++; $display("FAIL fixed_data[%0d] got v=%b d=%h s=%0d exp v=1 d=22 s=1", i, valid_f, data_f, sel_f);
      end
    end
  endtask

  task automatic test_mid_stall_reset();
    do_reset();
    req = 4'b0100;
    @(posedge clk); #1;
    ready = 1'b0; req = 4'b0000;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_r !== 4'b0000) begin failures++; $display("FAIL mrst_gnt got=%b exp=0000", gnt_r); end
    @(posedge clk); #1;
    checks++;
    if (valid_r !== 1'b0 || sel_r !== 2'd0) begin
      failures++; $display("FAIL mrst_regs got v=%b s=%0d exp v=0 s=0", valid_r, sel_r);
    end
    reset = 1'b0; ready = 1'b1; req = 4'b1001;
    @(negedge clk);
    checks++;
    if (gnt_r !== 4'b0001) begin failures++; $display("FAIL mrst_ptr0 got=%b exp=0001", gnt_r); end
    @(posedge clk); #1;
    req = 4'b1000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (gnt_r !== 4'b1000) begin failures++; $display("FAIL single_gnt[%0d] got=%b exp=1000", i, gnt_r); end
      @(posedge clk); #1;
      checks++;
      if (valid_r !== 1'b1 || data_r !== 8'h44 || sel_r !== 2'd3) begin
        failures++; $display("FAIL single_data[%0d] got v=%b d=%h s=%0d exp v=1 d=44 s=3", i, valid_r, data_r, sel_r);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    ready = 1'b1;
    data  = {8'h44, 8'h33, 8'h22, 8'h11};
    @(posedge clk); #1;
    test_reset();
    test_rr_rotate();
    test_wrap();
    test_backpressure();
    test_fixed_priority();
    test_mid_stall_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised N-input, W-bit registered multiplexer with built-in arbitration and a valid/ready output handshake.
- Generalises the 2:1 select mux:
  - the select is no longer an external pin;
  - an internal round-robin (or fixed-priority) arbiter picks among requesting channels;
  - the chosen data is registered into a one-entry output stage.
- Used wherever several producers share one downstream consumer.

Parameters:
- NUM_CH, 4, number of input channels (>= 2).
- DATA_W, 8, data width per channel.
- RR_EN, 1, 1 = round-robin priority rotation; 0 = fixed priority, channel 0 highest.
- SEL_W, $clog2(NUM_CH), width of the granted-index output (derived; not overridden).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_i  input  NUM_CH  per-channel request; channel k's data is valid while req_i[k]=1.
- data_i  input  NUM_CH*DATA_W  packed channel data; channel k occupies bits [k*DATA_W +: DATA_W].
- gnt_o  output  NUM_CH  combinational one-hot grant; gnt_o[k]=1 means channel k's data is captured at this edge.
- valid_o  output  1  output register holds a beat.
- data_o  output  DATA_W  registered data of the held beat.
- sel_o  output  SEL_W  registered index of the channel that supplied data_o.
- ready_i  input  1  downstream accepts data_o this cycle when valid_o=1.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: valid_o=0, data_o=0, sel_o=0, priority pointer ptr_q=0. gnt_o is forced to 0 while reset=1.
- Load condition: can_load = ~valid_o | ready_i. This gives full-throughput operation, one beat per cycle, with back-to-back transfers.
- Winner selection:
  - winner = first k with req_i[k]=1, scanning cyclically k = ptr_q, ptr_q+1, …, NUM_CH-1, 0, …, ptr_q-1.
  - In fixed mode (RR_EN=0), ptr_q is constantly 0.
- Grant: gnt_o = onehot(winner) when can_load & |req_i & ~reset; otherwise 0. Exactly zero or one bit is set.
- On a clock edge with a grant:
  - data_o <= data_i[winner]; sel_o <= winner; valid_o <= 1.
  - RR_EN=1: ptr_q <= (winner+1) mod NUM_CH, wrapping NUM_CH-1 -> 0.
- On a clock edge with no grant:
  - if valid_o & ready_i: valid_o <= 0;
  - data_o and sel_o hold their values.
- Stall: while valid_o=1 & ready_i=0:
  - data_o and sel_o are stable;
  - gnt_o=0;
  - ptr_q is unchanged.
- Latency: 1 cycle from grant to valid_o/data_o.
- Requester contract: a requester keeps req_i and data stable until it sees gnt_o; the block does not queue requests.
- Simultaneous events: ready_i=1 with a new grant in the same cycle pops the old beat and loads the new one; valid_o stays 1.
- Single requester: the same channel is granted every cycle in both modes.
- ready_i while valid_o=0 is ignored.
- Reset mid-operation: a held beat is discarded (valid_o=0) and the pointer returns to 0 at that edge; no grant is issued in the reset cycle.
- Required assertions:
  - gnt_o is onehot0.
  - gnt_o[k] implies req_i[k].
  - valid_o & ~ready_i |=> stable data_o, sel_o.
  - sel_o < NUM_CH.

Test Plan (NUM_CH=4, DATA_W=8):
1. Reset with req_i=4'b1111 -> gnt_o=0, valid_o=0, data_o=0, sel_o=0. Next cycle after release: gnt_o=4'b0001.
2. RR_EN=1, req_i=4'b1111 held, ready_i=1, data_i = {8'h44, 8'h33, 8'h22, 8'h11} -> grants 0,1,2,3,0 on consecutive cycles. data_o sequence 11,22,33,44,11 one cycle later; valid_o continuously 1.
3. RR_EN=1, ptr_q=2, req_i=4'b0011 -> grant wraps to channel 0; sel_o=0; ptr_q becomes 1.
4. Backpressure: beat from channel 1 loaded, ready_i=0 for 3 cycles with req_i=4'b1111 -> gnt_o=0, data_o/sel_o unchanged. Raise ready_i -> same-cycle grant to channel 2 and reload.
5. RR_EN=0, req_i=4'b1010 held, ready_i=1 -> channel 1 granted every cycle; channel 3 never granted.
6. Mid-stall reset: valid_o=1, ready_i=0, reset pulsed one cycle -> valid_o=0, ptr_q=0 after the edge. Next grant with req_i=4'b1000 goes to channel 3.
